// File: rtl/ds_pattern_sched.sv
// ds_pattern_sched: test-pattern sequencer for the delta-sigma path.
// Emits one of four periodic patterns at f_CLK/D. Pattern and rate changes
// take effect only at period wrap, so a period is never cut short.
module ds_pattern_sched #(
   parameter int WIDTH = 8,
   parameter int DIVW  = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             start,
   input  logic             stop,
   input  logic [1:0]       pattern,
   input  logic [DIVW-1:0]  div,
   output logic [WIDTH-1:0] sample,
   output logic             sample_stb,
   output logic             period_done,
   output logic             busy
);

   localparam logic [WIDTH-1:0] MID = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] MAX = '1;

   typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

   state_t            state, state_next;
   logic [WIDTH-1:0]  ph, ph_inc;
   logic [DIVW-1:0]   cnt, div_l, div_eff;
   logic [1:0]        pat_l;
   logic              tick, wrap, launch, finish;

   // Sample value of pattern p at phase `phase`.
   function automatic logic [WIDTH-1:0] pat_value(input logic [1:0] p,
                                                   input logic [WIDTH-1:0] phase);
      logic [WIDTH-1:0] t;
      t = {phase[WIDTH-2:0], 1'b0};
      case (p)
         2'b00:   pat_value = MID;
         2'b01:   pat_value = phase;
         2'b10:   pat_value = phase[WIDTH-1] ? MAX : '0;
         default: pat_value = phase[WIDTH-1] ? ~t : t;
      endcase
   endfunction

   // Next-state decode plus the one-cycle launch/tick/wrap/finish events.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
      state_next = state;
      tick       = 1'b0;
      wrap       = 1'b0;
      launch     = 1'b0;
      finish     = 1'b0;
      ph_inc     = ph + WIDTH'(1);
      div_eff    = (div == '0) ? DIVW'(1) : div;
      case (state)
         IDLE: begin
            if (start) begin
               launch     = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            tick = (cnt == '0);
            wrap = tick && (ph == MAX);
            if (wrap && stop) begin
               finish     = 1'b1;
               state_next = IDLE;
            end else if (stop) begin
               state_next = STOPPING;
            end
         end
         STOPPING: begin
            tick = (cnt == '0);
            wrap = tick && (ph == MAX);
            if (wrap) begin
               finish     = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // State register; busy is registered from the next state so it has no decode glitch.
   always_ff @(posedge CLK) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (RST) begin
         state <= IDLE;
         busy  <= 1'b0;
      end else begin
         state <= state_next;
         busy  <= (state_next != IDLE);
      end
   end

   // Phase, divider, latched settings and the registered sample outputs.
   always_ff @(posedge CLK) begin
      if (RST) begin
         ph          <= '0;
         cnt         <= '0;
         pat_l       <= 2'b00;
         div_l       <= DIVW'(1);
         sample      <= MID;
         sample_stb  <= 1'b0;
         period_done <= 1'b0;
      end else begin
         sample_stb  <= 1'b0;
         period_done <= 1'b0;
         if (launch) begin
            pat_l      <= pattern;
            div_l      <= div_eff;
            ph         <= '0;
            sample     <= pat_value(pattern, '0);
            sample_stb <= 1'b1;
            cnt        <= div_eff - DIVW'(1);
         end else if (finish) begin
            // Final strobe parks the output at midscale; divider freezes at 0.
            ph         <= '0;
            cnt        <= '0;
            sample     <= MID;
            sample_stb <= 1'b1;
         end else if (tick) begin
            ph          <= ph_inc;
            sample_stb  <= 1'b1;
            period_done <= (ph_inc == MAX);
            if (wrap) begin
               // New settings apply to the wrap sample and the interval starting now.
               pat_l  <= pattern;
               div_l  <= div_eff;
               sample <= pat_value(pattern, ph_inc);
               cnt    <= div_eff - DIVW'(1);
            end else begin
               sample <= pat_value(pat_l, ph_inc);
               cnt    <= div_l - DIVW'(1);
            end
         end else if (state != IDLE) begin
            cnt <= cnt - DIVW'(1);
         end
      end
   end

endmodule

// File: tb/tb_ds_pattern_sched.sv
// Self-checking bench for ds_pattern_sched (WIDTH=4) against a
// time-stamped behavioural model of the pattern sequencer.
module tb_ds_pattern_sched;

   localparam int W  = 4;
   localparam int DW = 8;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          start = 1'b0;
   logic          stop = 1'b0;
   logic [1:0]    pattern = 2'b00;
   logic [DW-1:0] div = '0;
   logic [W-1:0]  sample;
   logic          sample_stb;
   logic          period_done;
   logic          busy;

   int n_checks = 0;
   int n_errors = 0;

   ds_pattern_sched #(.WIDTH(W), .DIVW(DW)) dut (
      .CLK(CLK), .RST(RST), .start(start), .stop(stop),
      .pattern(pattern), .div(div),
      .sample(sample), .sample_stb(sample_stb),
      .period_done(period_done), .busy(busy)
   );

   always #5 CLK = ~CLK;

   // ---------------- behavioural model ----------------
   int cyc = 0;
   bit m_busy = 0, m_stopping = 0, m_stb = 0, m_pd = 0;
   int m_ph = 0, m_pat = 0, m_d = 1, m_next = 0, m_sample = 8;

   function automatic int ref_value(int p, int phase);
      case (p)
         0:       return 8;
         1:       return phase;
         2:       return (phase >= 8) ? 15 : 0;
         default: return (phase < 8) ? 2 * phase : 15 - 2 * (phase - 8);
      endcase
   endfunction

   // Model: strobes are scheduled by absolute cycle number.
   always @(posedge CLK) begin : model
      int d_in;
      bit stop_req;
      cyc = cyc + 1;
      m_stb = 0;
      m_pd = 0;
      d_in = (div == 0) ? 1 : int'(div);
      if (RST) begin
         m_busy = 0; m_stopping = 0; m_ph = 0; m_sample = 8;
      end else if (!m_busy) begin
         if (start) begin
            m_busy = 1; m_stopping = 0; m_pat = int'(pattern); m_d = d_in;
            m_ph = 0; m_sample = ref_value(m_pat, 0); m_stb = 1; m_next = cyc + m_d;
         end
      end else begin
         stop_req = stop && !m_stopping;
         if (cyc == m_next) begin
            m_ph = (m_ph + 1) % 16;
            if (m_ph == 0 && (m_stopping || stop_req)) begin
               m_busy = 0; m_stopping = 0; m_sample = 8; m_stb = 1;
            end else begin
               if (m_ph == 0) begin
                  m_pat = int'(pattern); m_d = d_in;
               end
               m_sample = ref_value(m_pat, m_ph);
               m_stb = 1;
               m_pd = (m_ph == 15);
               m_next = cyc + m_d;
               if (stop_req) m_stopping = 1;
            end
         end else if (stop_req) begin
            m_stopping = 1;
         end
      end
   end

   // ---------------- stimulus helpers (no checking) ----------------
   task automatic cycle();
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic do_reset();
      RST = 1'b1; start = 1'b0; stop = 1'b0;
      cycle();
      RST = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      RST = 1'b1;
      cycle();
      cycle();
      n_checks++;
      if (sample !== W'(8)) begin
         n_errors++;
         $display("FAIL reset_sample got=%0d exp=8", sample);
      end
      n_checks++;
      if ({sample_stb, period_done, busy} !== 3'b000) begin
         n_errors++;
         $display("FAIL reset_flags got stb/pd/busy=%b exp=000", {sample_stb, period_done, busy});
      end
      RST = 1'b0;
      cycle();
      n_checks++;
      if ({sample, sample_stb, busy} !== {W'(8), 1'b0, 1'b0}) begin
         n_errors++;
         $display("FAIL idle_hold got sample=%0d stb=%b busy=%b exp 8 0 0", sample, sample_stb, busy);
      end
   endtask

   task automatic test_sawtooth();
      int pd_count;
      pd_count = 0;
      do_reset();
      pattern = 2'b01; div = 8'd3; start = 1'b1;
      cycle();
      start = 1'b0;
      n_checks++;
      if ({sample, sample_stb, busy} !== {W'(0), 1'b1, 1'b1}) begin
         n_errors++;
         $display("FAIL saw_start got sample=%0d stb=%b busy=%b exp 0 1 1", sample, sample_stb, busy);
      end
      for (int i = 0; i < 52; i++) begin
         cycle();
         if (period_done) pd_count++;
         n_checks++;
         if ({sample, sample_stb, period_done, busy} !== {W'(m_sample), m_stb, m_pd, m_busy}) begin
            n_errors++;
            $display("FAIL sawtooth cyc=%0d got s=%0d stb=%b pd=%b busy=%b exp s=%0d stb=%b pd=%b busy=%b",
                     cyc, sample, sample_stb, period_done, busy, m_sample, m_stb, m_pd, m_busy);
         end
      end
      n_checks++;
      if (pd_count !== 1) begin
         n_errors++;
         $display("FAIL saw_period_done_count got=%0d exp=1", pd_count);
      end
   endtask

   task automatic test_tri_square();
      do_reset();
      pattern = 2'b11; div = 8'd1; start = 1'b1;
      cycle();
      start = 1'b0;
      pattern = 2'b10;
      for (int i = 0; i < 40; i++) begin
         cycle();
         n_checks++;
         if ({sample, sample_stb, period_done, busy} !== {W'(m_sample), m_stb, m_pd, m_busy}) begin
            n_errors++;
            $display("FAIL tri_square cyc=%0d got s=%0d stb=%b pd=%b busy=%b exp s=%0d stb=%b pd=%b busy=%b",
                     cyc, sample, sample_stb, period_done, busy, m_sample, m_stb, m_pd, m_busy);
         end
      end
   endtask

   task automatic test_deferred();
      do_reset();
      pattern = 2'b01; div = 8'd3; start = 1'b1;
      cycle();
      start = 1'b0;
      for (int i = 0; i < 80; i++) begin
         if (i == 20) begin
            pattern = 2'b10; div = 8'd5;
         end
         cycle();
         n_checks++;
         if ({sample, sample_stb, period_done, busy} !== {W'(m_sample), m_stb, m_pd, m_busy}) begin
            n_errors++;
            $display("FAIL deferred cyc=%0d got s=%0d stb=%b pd=%b busy=%b exp s=%0d stb=%b pd=%b busy=%b",
                     cyc, sample, sample_stb, period_done, busy, m_sample, m_stb, m_pd, m_busy);
         end
      end
   endtask

   task automatic test_stop();
      int guard;
      do_reset();
      pattern = 2'b01; div = 8'd2; start = 1'b1;
      cycle();
      start = 1'b0;
      guard = 0;
      while (!(m_stb && m_ph == 6) && guard < 100) begin
         cycle();
         guard++;
      end
      n_checks++;
      if (guard >= 100) begin
         n_errors++;
         $display("FAIL stop_reach_phase6 timed out");
      end
      stop = 1'b1;
      cycle();
      stop = 1'b0;
      start = 1'b1;   // held through STOPPING: must be ignored
      guard = 0;
      while (m_busy && guard < 60) begin
         n_checks++;
         if ({sample, sample_stb, period_done, busy} !== {W'(m_sample), m_stb, m_pd, m_busy}) begin
            n_errors++;
            $display("FAIL stopping cyc=%0d got s=%0d stb=%b pd=%b busy=%b exp s=%0d stb=%b pd=%b busy=%b",
                     cyc, sample, sample_stb, period_done, busy, m_sample, m_stb, m_pd, m_busy);
         end
         cycle();
         guard++;
      end
      start = 1'b0;
      n_checks++;
      if ({sample, sample_stb, busy} !== {W'(8), 1'b1, 1'b0}) begin
         n_errors++;
         $display("FAIL stop_final got sample=%0d stb=%b busy=%b exp 8 1 0", sample, sample_stb, busy);
      end
      cycle();
      start = 1'b1;
      cycle();
      start = 1'b0;
      n_checks++;
      if ({sample, sample_stb, busy} !== {W'(0), 1'b1, 1'b1}) begin
         n_errors++;
         $display("FAIL restart_after_stop got sample=%0d stb=%b busy=%b exp 0 1 1", sample, sample_stb, busy);
      end
   endtask

   task automatic test_div0_simul();
      int guard;
      do_reset();
      pattern = 2'b01; div = 8'd0; start = 1'b1; stop = 1'b1;
      cycle();
      start = 1'b0; stop = 1'b0;
      n_checks++;
      if ({sample_stb, busy} !== 2'b11) begin
         n_errors++;
         $display("FAIL start_stop_idle got stb=%b busy=%b exp 1 1", sample_stb, busy);
      end
      guard = 0;
      while (m_ph != 15 && guard < 40) begin
         cycle();
         guard++;
         n_checks++;
         if ({sample, sample_stb, period_done, busy} !== {W'(m_sample), m_stb, m_pd, m_busy}) begin
            n_errors++;
            $display("FAIL div0 cyc=%0d got s=%0d stb=%b pd=%b busy=%b exp s=%0d stb=%b pd=%b busy=%b",
                     cyc, sample, sample_stb, period_done, busy, m_sample, m_stb, m_pd, m_busy);
         end
      end
      stop = 1'b1;
      cycle();
      stop = 1'b0;
      n_checks++;
      if ({sample, sample_stb, busy} !== {W'(8), 1'b1, 1'b0}) begin
         n_errors++;
         $display("FAIL stop_on_wrap got sample=%0d stb=%b busy=%b exp 8 1 0", sample, sample_stb, busy);
      end
   endtask

   task automatic test_reset_mid();
      int guard;
      do_reset();
      pattern = 2'b11; div = 8'd2; start = 1'b1;
      cycle();
      start = 1'b0;
      guard = 0;
      while (!(m_stb && m_ph == 9) && guard < 100) begin
         cycle();
         guard++;
      end
      RST = 1'b1; stop = 1'b1; start = 1'b1;
      cycle();
      RST = 1'b0; stop = 1'b0; start = 1'b0;
      n_checks++;
      if ({sample, sample_stb, period_done, busy} !== {W'(8), 1'b0, 1'b0, 1'b0}) begin
         n_errors++;
         $display("FAIL reset_mid got sample=%0d stb=%b pd=%b busy=%b exp 8 0 0 0",
                  sample, sample_stb, period_done, busy);
      end
      pattern = 2'b01; start = 1'b1;
      cycle();
      start = 1'b0;
      n_checks++;
      if ({sample, sample_stb, busy} !== {W'(0), 1'b1, 1'b1}) begin
         n_errors++;
         $display("FAIL restart_after_reset got sample=%0d stb=%b busy=%b exp 0 1 1", sample, sample_stb, busy);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         start   = ($urandom_range(0, 15) == 0);
         stop    = ($urandom_range(0, 31) == 0);
         RST     = ($urandom_range(0, 299) == 0);
         pattern = 2'($urandom_range(0, 3));
         div     = DW'($urandom_range(0, 3));
         cycle();
         n_checks++;
         if ({sample, sample_stb, period_done, busy} !== {W'(m_sample), m_stb, m_pd, m_busy}) begin
            n_errors++;
            $display("FAIL random cyc=%0d got s=%0d stb=%b pd=%b busy=%b exp s=%0d stb=%b pd=%b busy=%b",
                     cyc, sample, sample_stb, period_done, busy, m_sample, m_stb, m_pd, m_busy);
         end
      end
      RST = 1'b0; start = 1'b0; stop = 1'b0;
   endtask

   initial begin
      @(negedge CLK);
      test_reset();
      test_sawtooth();
      test_tri_square();
      test_deferred();
      test_stop();
      test_div0_simul();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
